regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Writeback sequencer that drives the write port of the core's 16×32 register file. It accepts single-register results from execute and multi-register load sequences (LDM/POP) from memory, and emits at most one registered write per cycle in ascending register order. It also applies optional base-register writeback, redirects r15 writes to the fetch unit as a branch, and stalls the pipeline while a sequence is in flight.

## Interface
Parameters:
- none (register count 16, data width 32, PC index 15 are fixed)

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `i_alu_valid`  in  1  single-write request from execute, one-cycle pulse
- `i_alu_addr`  in  4  destination register of ALU write
- `i_alu_data`  in  32  ALU result
- `i_ldm_start`  in  1  start load-multiple, one-cycle pulse
- `i_ldm_list`  in  16  register list, bit n = load rn
- `i_ldm_base`  in  4  base register index
- `i_ldm_base_val`  in  32  updated base value for writeback
- `i_ldm_wb`  in  1  base writeback requested
- `i_mem_valid`  in  1  memory data beat valid
- `i_mem_data`  in  32  memory data beat
- `o_mem_ready`  out  1  block accepts a beat this cycle
- `o_rd`  out  32  write data to register file
- `o_addr_rd`  out  4  write address to register file
- `o_rd_wr_en`  out  1  write enable to register file
- `o_branch_en`  out  1  one-cycle pulse: r15 was written
- `o_branch_target`  out  32  value written to r15
- `o_stall`  out  1  pipeline stall to decode/execute
- `o_busy`  out  1  state != IDLE

## Operation
- States: IDLE, LOAD, BASE_WB.
- IDLE: `i_ldm_start` with nonzero list → LOAD; zero list with `i_ldm_wb` → BASE_WB; zero list without wb → stay IDLE (no-op).
- LOAD: `o_mem_ready`=1. Each accepted beat (valid & ready) is written to the lowest remaining set bit of the latched list; the bit is then cleared. When the last bit is consumed → BASE_WB if `i_ldm_wb` latched and base not in list, else IDLE.
- Base in list with wb set: loaded value wins, base writeback suppressed.
- BASE_WB: one write of latched base value to latched base index → IDLE.
- `i_ldm_start` while not IDLE: ignored.
- ALU writes: in IDLE with no pending buffer, emitted directly. While busy, captured in a one-entry holding buffer and drained in the first IDLE cycle, ahead of any new request. A request while the buffer is full is a protocol violation and is dropped.
- Same-cycle `i_alu_valid` and `i_ldm_start` in IDLE: both accepted; ALU write emitted first.
- Write to index 15: `o_rd_wr_en` suppressed; `o_branch_en` pulsed with `o_branch_target` = data (see Configuration).
- `o_stall` = `o_busy` | buffer full.

## Timing
- All outputs registered except `o_mem_ready`, `o_stall` and `o_busy`, which decode state combinationally.
- Reset values: all outputs 0, state IDLE, buffer empty, latched list 0.
- ALU request at edge N → write visible N+1.
- Beat accepted at edge N → write visible N+1.
- Base writeback follows the last load write by one cycle.
- `o_rd_wr_en` and `o_branch_en` are one-cycle pulses, never asserted together.
- Reset mid-sequence aborts immediately: no further writes, and the latched list and buffer are cleared.

## Configuration
- `REGWB_PC_BRANCH_EN` defined: r15 writes produce an `o_branch_en` pulse with target.
- Undefined: r15 writes are silently discarded; `o_branch_en` and `o_branch_target` are tied 0.

## Test plan
- ALU write r3=0x1234 at cycle 0 → cycle 1: `o_rd_wr_en`=1, `o_addr_rd`=3, `o_rd`=0x1234; cycle 2 enable low.
- LDM list 0x0092, no wb, beats 0xA,0xB,0xC back-to-back → writes r1=0xA, r4=0xB, r7=0xC on consecutive cycles; `o_busy` falls after third beat.
- LDM list 0x0003, base r13, wb, base_val 0x100, beats with one idle cycle between → r0, r1, then r13=0x100; ALU write r5 issued mid-sequence buffered and written the cycle after IDLE returns.
- LDM list 0x8000 with macro defined, beat 0x2000 → `o_branch_en`=1, target 0x2000, `o_rd_wr_en`=0; without macro → no pulse.
- LDM list 0x2001, base r13, wb → r0 and r13 loaded from memory, no base writeback.
- Assert `rst` low after first of three beats → outputs 0 asynchronously; after release IDLE, `o_mem_ready`=0, no residual writes.

Source files
------------

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: bundles the execute, memory and register-file-side
// signals of the writeback sequencer. The master modport is the side that
// drives requests and beats. The slave modport is the sequencer itself.
interface regfile_writeback_if;
  logic        i_alu_valid;
  logic [3:0]  i_alu_addr;
  logic [31:0] i_alu_data;
  logic        i_ldm_start;
  logic [15:0] i_ldm_list;
  logic [3:0]  i_ldm_base;
  logic [31:0] i_ldm_base_val;
  logic        i_ldm_wb;
  logic        i_mem_valid;
  logic [31:0] i_mem_data;
  logic        o_mem_ready;
  logic [31:0] o_rd;
  logic [3:0]  o_addr_rd;
  logic        o_rd_wr_en;
  logic        o_branch_en;
  logic [31:0] o_branch_target;
  logic        o_stall;
  logic        o_busy;

  modport master (
    output i_alu_valid, i_alu_addr, i_alu_data,
    output i_ldm_start, i_ldm_list, i_ldm_base, i_ldm_base_val, i_ldm_wb,
    output i_mem_valid, i_mem_data,
    input  o_mem_ready, o_rd, o_addr_rd, o_rd_wr_en,
    input  o_branch_en, o_branch_target, o_stall, o_busy
  );

  modport slave (
    input  i_alu_valid, i_alu_addr, i_alu_data,
    input  i_ldm_start, i_ldm_list, i_ldm_base, i_ldm_base_val, i_ldm_wb,
    input  i_mem_valid, i_mem_data,
    output o_mem_ready, o_rd, o_addr_rd, o_rd_wr_en,
    output o_branch_en, o_branch_target, o_stall, o_busy
  );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: drives the single write port of the 16x32 register file.
// It merges ALU results and load-multiple sequences into at most one write per
// cycle, in ascending register order. It also performs the optional
// base-register writeback and holds off the pipeline while a sequence runs.
// Optional feature macro: REGWB_PC_BRANCH_EN. When it is defined, r15 writes
// become a branch pulse to fetch. When it is undefined, r15 writes are dropped.
module regfile_writeback (
  input logic                clk,
  input logic                rst,
  regfile_writeback_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, BASE_WB} state_t;

  state_t      state;
  logic [15:0] list;
  logic [3:0]  base_idx;
  logic [31:0] base_val;
  logic        base_wb;

  logic        buf_valid;
  logic [3:0]  buf_addr;
  logic [31:0] buf_data;

  logic [31:0] rd_q;
  logic [3:0]  addr_q;
  logic        wr_en_q;

  logic [3:0]  low_idx;
  logic [15:0] list_rest;

  logic        wr_req;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  // Find the lowest register still pending in the latched list, and the list
  // that remains once that register has been consumed.
  always_comb begin
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (list[i]) low_idx = i[3:0];
    end
    list_rest = list & (list - 16'd1);
  end

  // Choose the one write for this cycle. In IDLE a held ALU result goes first.
  // In LOAD each accepted beat is written. In BASE_WB the base value is written.
  always_comb begin
    wr_req  = 1'b0;
    wr_addr = 4'd0;
    wr_data = 32'd0;
    case (state)
      IDLE: begin
        if (buf_valid) begin
          wr_req  = 1'b1;
          wr_addr = buf_addr;
          wr_data = buf_data;
        end else if (bus.i_alu_valid) begin
          wr_req  = 1'b1;
          wr_addr = bus.i_alu_addr;
          wr_data = bus.i_alu_data;
        end
      end
      LOAD: begin
        if (bus.i_mem_valid) begin
          wr_req  = 1'b1;
          wr_addr = low_idx;
          wr_data = bus.i_mem_data;
        end
      end
      BASE_WB: begin
        wr_req  = 1'b1;
        wr_addr = base_idx;
        wr_data = base_val;
      end
      default: ;
    endcase
  end

`ifdef REGWB_PC_BRANCH_EN
  logic        branch_en_q;
  logic [31:0] branch_target_q;
`endif

  // This block holds the sequencer state, the ALU holding buffer and the
  // registered write-port outputs. A write to r15 is turned away from the
  // register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      list      <= 16'd0;
      base_idx  <= 4'd0;
      base_val  <= 32'd0;
      base_wb   <= 1'b0;
      buf_valid <= 1'b0;
      buf_addr  <= 4'd0;
      buf_data  <= 32'd0;
      rd_q      <= 32'd0;
      addr_q    <= 4'd0;
      wr_en_q   <= 1'b0;
`ifdef REGWB_PC_BRANCH_EN
      branch_en_q     <= 1'b0;
      branch_target_q <= 32'd0;
`endif
    end else begin
      wr_en_q <= 1'b0;
`ifdef REGWB_PC_BRANCH_EN
      branch_en_q <= 1'b0;
`endif
      if (wr_req) begin
        if (wr_addr == 4'd15) begin
`ifdef REGWB_PC_BRANCH_EN
          branch_en_q     <= 1'b1;
          branch_target_q <= wr_data;
`endif
        end else begin
          wr_en_q <= 1'b1;
          addr_q  <= wr_addr;
          rd_q    <= wr_data;
        end
      end

      if (state == IDLE && buf_valid) begin
        buf_valid <= bus.i_alu_valid;
        buf_addr  <= bus.i_alu_addr;
        buf_data  <= bus.i_alu_data;
      end else if (state != IDLE && bus.i_alu_valid && !buf_valid) begin
        buf_valid <= 1'b1;
        buf_addr  <= bus.i_alu_addr;
        buf_data  <= bus.i_alu_data;
      end

      case (state)
        IDLE: begin
          if (bus.i_ldm_start) begin
            list     <= bus.i_ldm_list;
            base_idx <= bus.i_ldm_base;
            base_val <= bus.i_ldm_base_val;
            base_wb  <= bus.i_ldm_wb && !bus.i_ldm_list[bus.i_ldm_base];
            if (bus.i_ldm_list != 16'd0) state <= LOAD;
            else if (bus.i_ldm_wb)       state <= BASE_WB;
          end
        end
        LOAD: begin
          if (bus.i_mem_valid) begin
            list <= list_rest;
            if (list_rest == 16'd0) state <= base_wb ? BASE_WB : IDLE;
          end
        end
        BASE_WB: begin
          base_wb <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_rd        = rd_q;
  assign bus.o_addr_rd   = addr_q;
  assign bus.o_rd_wr_en  = wr_en_q;
  assign bus.o_mem_ready = (state == LOAD);
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_stall     = (state != IDLE) || buf_valid;
`ifdef REGWB_PC_BRANCH_EN
  assign bus.o_branch_en     = branch_en_q;
  assign bus.o_branch_target = branch_target_q;
`else
  assign bus.o_branch_en     = 1'b0;
  assign bus.o_branch_target = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: scoreboard bench for regfile_writeback. Each expected
// register write or branch pulse is queued in emission order when its stimulus
// is driven. The queue is checked every cycle against the DUT outputs.
// It honours REGWB_PC_BRANCH_EN in the same way as the design.
module tb_regfile_writeback;

  logic clk;
  logic rst;
  regfile_writeback_if bus();

  regfile_writeback dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          branch;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic push_reg(input logic [3:0] addr, input logic [31:0] data);
    exp_t e;
    if (addr == 4'd15) begin
`ifdef REGWB_PC_BRANCH_EN
      e.branch = 1'b1;
      e.addr   = addr;
      e.data   = data;
      exp_q.push_back(e);
`endif
    end else begin
      e.branch = 1'b0;
      e.addr   = addr;
      e.data   = data;
      exp_q.push_back(e);
    end
  endtask

  // Queue the writes of a load-multiple. Beat k carries first+k.
  task automatic push_ldm(input logic [15:0] lst, input logic [31:0] first,
                          input logic wb, input logic [3:0] base,
                          input logic [31:0] bval);
    logic [31:0] d;
    d = first;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        push_reg(i[3:0], d);
        d = d + 32'd1;
      end
    end
    if (wb && !lst[base]) push_reg(base, bval);
  endtask

  // Advance one cycle, sample 1 time unit after the edge, and compare any
  // write or branch pulse against the head of the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.o_rd_wr_en === 1'b1 && bus.o_branch_en === 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL pulse_overlap: wr_en=%b branch_en=%b required not both", bus.o_rd_wr_en, bus.o_branch_en);
    end
    if (bus.o_rd_wr_en === 1'b1 || bus.o_branch_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: addr=%0d data=%h branch=%b required no write", bus.o_addr_rd, bus.o_rd, bus.o_branch_en);
      end else begin
        e = exp_q.pop_front();
        if (bus.o_branch_en === 1'b1) begin
          if (!e.branch || bus.o_branch_target !== e.data) begin
            errors++;
            $display("[TB] FAIL branch: target=%h required branch=%b addr=%0d data=%h", bus.o_branch_target, e.branch, e.addr, e.data);
          end
        end else if (e.branch || bus.o_addr_rd !== e.addr || bus.o_rd !== e.data) begin
          errors++;
          $display("[TB] FAIL write: addr=%0d data=%h required branch=%b addr=%0d data=%h", bus.o_addr_rd, bus.o_rd, e.branch, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic beat(input logic [31:0] d);
    bus.i_mem_valid = 1'b1;
    bus.i_mem_data  = d;
    tick();
    bus.i_mem_valid = 1'b0;
  endtask

  // Wait, with a cycle budget, until every queued write has been seen.
  task automatic wait_drain(input string name);
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: %0d writes outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.o_rd !== 32'd0 || bus.o_addr_rd !== 4'd0 || bus.o_rd_wr_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_wr: rd=%h addr=%0d en=%b required 0", bus.o_rd, bus.o_addr_rd, bus.o_rd_wr_en);
    end
    checks++;
    if (bus.o_branch_en !== 1'b0 || bus.o_branch_target !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_branch: en=%b target=%h required 0", bus.o_branch_en, bus.o_branch_target);
    end
    checks++;
    if (bus.o_mem_ready !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: ready=%b busy=%b stall=%b required 0", bus.o_mem_ready, bus.o_busy, bus.o_stall);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_alu_write();
    bus.i_alu_valid = 1'b1;
    bus.i_alu_addr  = 4'd3;
    bus.i_alu_data  = 32'h1234;
    push_reg(4'd3, 32'h1234);
    tick();
    bus.i_alu_valid = 1'b0;
    checks++;
    if (bus.o_rd_wr_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL alu_latency: en=%b required 1", bus.o_rd_wr_en);
    end
    tick();
    checks++;
    if (bus.o_rd_wr_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alu_pulse: en=%b required 0", bus.o_rd_wr_en);
    end
    // Back-to-back ALU writes
    for (int k = 0; k < 3; k++) begin
      bus.i_alu_valid = 1'b1;
      bus.i_alu_addr  = 4'(2 + 4 * k);
      bus.i_alu_data  = 32'h11 * (k + 1);
      push_reg(4'(2 + 4 * k), 32'h11 * (k + 1));
      tick();
    end
    bus.i_alu_valid = 1'b0;
    wait_drain("alu");
  endtask

  task automatic test_ldm_basic();
    bus.i_ldm_start = 1'b1;
    bus.i_ldm_list  = 16'h0092;
    bus.i_ldm_wb    = 1'b0;
    bus.i_ldm_base  = 4'd0;
    push_ldm(16'h0092, 32'hA, 1'b0, 4'd0, 32'd0);
    tick();
    bus.i_ldm_start = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_mem_ready !== 1'b1 || bus.o_stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ldm_enter: busy=%b ready=%b stall=%b required 1", bus.o_busy, bus.o_mem_ready, bus.o_stall);
    end
    // This start arrives while busy and must be ignored.
    bus.i_ldm_start = 1'b1;
    bus.i_ldm_list  = 16'h0F00;
    beat(32'hA);
    bus.i_ldm_start = 1'b0;
    beat(32'hB);
    beat(32'hC);
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_mem_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ldm_exit: busy=%b ready=%b required 0", bus.o_busy, bus.o_mem_ready);
    end
    wait_drain("ldm_basic");
  endtask

  task automatic test_ldm_wb_buffered();
    bus.i_ldm_start    = 1'b1;
    bus.i_ldm_list     = 16'h0003;
    bus.i_ldm_base     = 4'd13;
    bus.i_ldm_base_val = 32'h100;
    bus.i_ldm_wb       = 1'b1;
    push_ldm(16'h0003, 32'h50, 1'b1, 4'd13, 32'h100);
    tick();
    bus.i_ldm_start = 1'b0;
    bus.i_ldm_wb    = 1'b0;
    beat(32'h50);
    bus.i_alu_valid = 1'b1;
    bus.i_alu_addr  = 4'd5;
    bus.i_alu_data  = 32'h555;
    push_reg(4'd5, 32'h555);
    tick();
    bus.i_alu_valid = 1'b0;
    checks++;
    if (bus.o_stall !== 1'b1 || bus.o_rd_wr_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wb_gap: stall=%b en=%b required stall=1 en=0", bus.o_stall, bus.o_rd_wr_en);
    end
    beat(32'h51);
    tick();
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_stall !== 1'b1 || bus.o_addr_rd !== 4'd13) begin
      errors++;
      $display("[TB] FAIL wb_base: busy=%b stall=%b addr=%0d required busy=0 stall=1 addr=13", bus.o_busy, bus.o_stall, bus.o_addr_rd);
    end
    tick();
    checks++;
    if (bus.o_rd_wr_en !== 1'b1 || bus.o_addr_rd !== 4'd5 || bus.o_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wb_buffer_drain: en=%b addr=%0d stall=%b required en=1 addr=5 stall=0", bus.o_rd_wr_en, bus.o_addr_rd, bus.o_stall);
    end
    wait_drain("ldm_wb");
  endtask

  task automatic test_pc_write();
    logic exp_br;
`ifdef REGWB_PC_BRANCH_EN
    exp_br = 1'b1;
`else
    exp_br = 1'b0;
`endif
    bus.i_alu_valid = 1'b1;
    bus.i_alu_addr  = 4'd15;
    bus.i_alu_data  = 32'h3000;
    push_reg(4'd15, 32'h3000);
    tick();
    bus.i_alu_valid = 1'b0;
    checks++;
    if (bus.o_branch_en !== exp_br || bus.o_rd_wr_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pc_alu: branch=%b en=%b required branch=%b en=0", bus.o_branch_en, bus.o_rd_wr_en, exp_br);
    end
    bus.i_ldm_start = 1'b1;
    bus.i_ldm_list  = 16'h8000;
    bus.i_ldm_wb    = 1'b0;
    push_ldm(16'h8000, 32'h2000, 1'b0, 4'd0, 32'd0);
    tick();
    bus.i_ldm_start = 1'b0;
    beat(32'h2000);
    checks++;
    if (bus.o_branch_en !== exp_br || bus.o_rd_wr_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pc_ldm: branch=%b en=%b required branch=%b en=0", bus.o_branch_en, bus.o_rd_wr_en, exp_br);
    end
    wait_drain("pc");
  endtask

  task automatic test_base_in_list();
    bus.i_ldm_start    = 1'b1;
    bus.i_ldm_list     = 16'h2001;
    bus.i_ldm_base     = 4'd13;
    bus.i_ldm_base_val = 32'hDEAD;
    bus.i_ldm_wb       = 1'b1;
    push_ldm(16'h2001, 32'h70, 1'b1, 4'd13, 32'hDEAD);
    tick();
    bus.i_ldm_start = 1'b0;
    bus.i_ldm_wb    = 1'b0;
    beat(32'h70);
    beat(32'h71);
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL base_in_list_busy: busy=%b required 0", bus.o_busy);
    end
    wait_drain("base_in_list");
  endtask

  task automatic test_zero_list();
    bus.i_ldm_start    = 1'b1;
    bus.i_ldm_list     = 16'h0000;
    bus.i_ldm_base     = 4'd9;
    bus.i_ldm_base_val = 32'hCAFE;
    bus.i_ldm_wb       = 1'b1;
    push_reg(4'd9, 32'hCAFE);
    tick();
    bus.i_ldm_start = 1'b0;
    bus.i_ldm_wb    = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_mem_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_list_wb: busy=%b ready=%b required busy=1 ready=0", bus.o_busy, bus.o_mem_ready);
    end
    tick();
    bus.i_ldm_start = 1'b1;
    tick();
    bus.i_ldm_start = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_rd_wr_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_list_noop: busy=%b en=%b required 0", bus.o_busy, bus.o_rd_wr_en);
    end
    wait_drain("zero_list");
  endtask

  task automatic test_back_to_back();
    bus.i_alu_valid = 1'b1;
    bus.i_alu_addr  = 4'd2;
    bus.i_alu_data  = 32'h77;
    bus.i_ldm_start = 1'b1;
    bus.i_ldm_list  = 16'h0010;
    bus.i_ldm_wb    = 1'b0;
    push_reg(4'd2, 32'h77);
    push_ldm(16'h0010, 32'h99, 1'b0, 4'd0, 32'd0);
    tick();
    bus.i_alu_valid = 1'b0;
    bus.i_ldm_start = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_rd_wr_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL same_cycle: busy=%b en=%b required 1", bus.o_busy, bus.o_rd_wr_en);
    end
    beat(32'h99);
    wait_drain("same_cycle");
  endtask

  task automatic test_reset_midseq();
    bus.i_ldm_start = 1'b1;
    bus.i_ldm_list  = 16'h0007;
    bus.i_ldm_wb    = 1'b0;
    push_ldm(16'h0007, 32'h40, 1'b0, 4'd0, 32'd0);
    tick();
    bus.i_ldm_start = 1'b0;
    bus.i_alu_valid = 1'b1;
    bus.i_alu_addr  = 4'd8;
    bus.i_alu_data  = 32'h888;
    beat(32'h40);
    bus.i_alu_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (bus.o_rd_wr_en !== 1'b0 || bus.o_rd !== 32'd0 || bus.o_addr_rd !== 4'd0) begin
      errors++;
      $display("[TB] FAIL rst_async: en=%b rd=%h addr=%0d required 0", bus.o_rd_wr_en, bus.o_rd, bus.o_addr_rd);
    end
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_stall !== 1'b0 || bus.o_mem_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_ctrl: busy=%b stall=%b ready=%b required 0", bus.o_busy, bus.o_stall, bus.o_mem_ready);
    end
    tick();
    rst = 1'b1;
    bus.i_mem_valid = 1'b1;
    bus.i_mem_data  = 32'h41;
    for (int k = 0; k < 4; k++) tick();
    bus.i_mem_valid = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_mem_ready !== 1'b0 || bus.o_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_release: busy=%b ready=%b stall=%b required 0", bus.o_busy, bus.o_mem_ready, bus.o_stall);
    end
    wait_drain("rst_midseq");
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    rst                = 1'b0;
    bus.i_alu_valid    = 1'b0;
    bus.i_alu_addr     = 4'd0;
    bus.i_alu_data     = 32'd0;
    bus.i_ldm_start    = 1'b0;
    bus.i_ldm_list     = 16'd0;
    bus.i_ldm_base     = 4'd0;
    bus.i_ldm_base_val = 32'd0;
    bus.i_ldm_wb       = 1'b0;
    bus.i_mem_valid    = 1'b0;
    bus.i_mem_data     = 32'd0;

    test_reset();
    test_alu_write();
    test_ldm_basic();
    test_ldm_wb_buffered();
    test_pc_write();
    test_base_in_list();
    test_zero_list();
    test_back_to_back();
    test_reset_midseq();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
